// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage types: machine word, fetch FIFO entry,
// and the default fetch queue depth.
package instruction_fetch_unit_pkg;

  typedef logic [31:0] word;

  typedef struct packed {
    word addr;
    word instr;
  } fetch_entry_t;

  localparam int IFU_DEPTH = 4;

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// Small synchronous FIFO with clear, count and head.
// Clear takes priority over push and pop.
module fetch_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4,
  parameter int  CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output T                 head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  T mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push)
                     - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: issues PC addresses to imem under a credit limit,
// pairs responses with addresses, drops stale ones after a flush.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = IFU_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] s1a_instruction_addr,
  input  logic        do_flush,
  input  logic        stall,
  output logic        pc_stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        s2_valid,
  output logic [31:0] s2_instruction,
  output logic [31:0] s2_instruction_addr
);

  localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(DEPTH);

  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W:0]   used;

  word          pend_head;
  fetch_entry_t resp_entry;
  fetch_entry_t out_head;

  logic space;
  logic issue;
  logic resp;
  logic discard;
  logic pop;

  // Credit counts both in-flight fetches and buffered entries.
  assign used  = {1'b0, outstanding} + {1'b0, fifo_count};
  assign space = used < LIMIT;

  assign imem_req_valid = !reset && space;
  assign imem_req_addr  = s1a_instruction_addr;
  assign issue          = imem_req_valid && imem_req_ready;
  assign pc_stall       = !issue;

  assign resp    = imem_resp_valid && (outstanding != '0);
  assign discard = do_flush || (drop_cnt != '0);

  assign s2_valid = (fifo_count != '0) && !do_flush;
  assign pop      = s2_valid && !stall;

  assign resp_entry = '{addr: pend_head, instr: imem_resp_data};

  assign s2_instruction      = out_head.instr;
  assign s2_instruction_addr = out_head.addr;

  fetch_fifo #(
    .T     (word),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_pend (
    .clock     (clock),
    .reset     (reset),
    .clear     (1'b0),
    .push      (issue),
    .push_data (s1a_instruction_addr),
    .pop       (resp),
    .count     (outstanding),
    .head      (pend_head)
  );

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_out (
    .clock     (clock),
    .reset     (reset),
    .clear     (do_flush),
    .push      (resp && !discard),
    .push_data (resp_entry),
    .pop       (pop),
    .count     (fifo_count),
    .head      (out_head)
  );

  // The fetch issued in a flush cycle is the new target, so it
  // is not counted among the responses to drop.
  always_ff @(posedge clock) begin
    if (reset)
      drop_cnt <= '0;
    else if (do_flush)
      drop_cnt <= outstanding - CNT_W'(resp);
    else if (resp && (drop_cnt != '0))
      drop_cnt <= drop_cnt - 1'b1;
  end

  a_resp_legal: assert property (
    @(posedge clock) disable iff (reset)
    imem_resp_valid |-> (outstanding != '0)
  );

  a_credit_bound: assert property (
    @(posedge clock) disable iff (reset)
    (used <= LIMIT) && (drop_cnt <= CNT_W'(DEPTH))
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: PC and imem models, expected-entry queue,
// and a monitor checking every s2 entry decode accepts.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam word BOOT_ADDRESS = 32'h0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  word  s1a_instruction_addr = BOOT_ADDRESS;
  logic do_flush = 1'b0;
  logic stall = 1'b0;
  logic pc_stall;
  logic imem_req_valid;
  word  imem_req_addr;
  logic imem_req_ready = 1'b0;
  logic imem_resp_valid = 1'b0;
  word  imem_resp_data = '0;
  logic s2_valid;
  word  s2_instruction;
  word  s2_instruction_addr;

  always #5 clock = ~clock;

  instruction_fetch_unit dut (
    .clock                (clock),
    .reset                (reset),
    .s1a_instruction_addr (s1a_instruction_addr),
    .do_flush             (do_flush),
    .stall                (stall),
    .pc_stall             (pc_stall),
    .imem_req_valid       (imem_req_valid),
    .imem_req_addr        (imem_req_addr),
    .imem_req_ready       (imem_req_ready),
    .imem_resp_valid      (imem_resp_valid),
    .imem_resp_data       (imem_resp_data),
    .s2_valid             (s2_valid),
    .s2_instruction       (s2_instruction),
    .s2_instruction_addr  (s2_instruction_addr)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  int last_due = 0;
  int issues;

  typedef struct {
    word addr;
    int  due;
  } mreq_t;

  mreq_t        mq[$];
  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;

  logic adv = 1'b0;
  logic rst_s = 1'b1;
  logic flush_req = 1'b0;
  word  flush_target = '0;

  function automatic word mdata(word a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(string name, word act, word exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Memory: in order, fixed latency in cycles after issue.
  always @(negedge clock) begin
    int d;
    if (imem_resp_valid && mq.size() > 0)
      void'(mq.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      d = cyc + 1 + lat;
      if (d <= last_due)
        d = last_due + 1;
      last_due = d;
      mq.push_back('{imem_req_addr, d});
    end
  end

  always @(posedge clock) begin
    cyc++;
    if (reset)
      mq.delete();
    #1;
    if (mq.size() > 0 && mq[0].due == cyc + 1) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mdata(mq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  end

  // Program counter: advances only on cycles it was accepted.
  always @(negedge clock) begin
    adv   = !pc_stall;
    rst_s = reset;
  end

  always @(posedge clock) begin
    #2;
    do_flush = 1'b0;
    if (rst_s) begin
      s1a_instruction_addr = BOOT_ADDRESS;
    end else begin
      if (adv)
        s1a_instruction_addr = s1a_instruction_addr + 32'd4;
      if (flush_req) begin
        s1a_instruction_addr = flush_target;
        do_flush  = 1'b1;
        flush_req = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && s2_valid && !stall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL s2_unexpected: got addr %h expected none",
                 s2_instruction_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("s2_addr", s2_instruction_addr, mon_e.addr);
        check("s2_instr", s2_instruction, mon_e.instr);
      end
    end
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
    #0;
  endtask

  task automatic expect_entry(word a);
    exp_q.push_back('{addr: a, instr: mdata(a)});
  endtask

  task automatic drain(string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      next();
      k++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) next();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    next();
    at_neg();
    check("rst_s2_valid", s2_valid, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_pc_stall", pc_stall, 1);
    next();

    // Back-to-back fetches, latency 1, no stall
    reset = 1'b0;
    imem_req_ready = 1'b1;
    lat = 1;
    expect_entry(32'h0);
    expect_entry(32'h4);
    expect_entry(32'h8);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("t1_pc_stall", pc_stall, 0);
      check("t1_req_addr", imem_req_addr, 32'(4 * i));
      next();
    end
    imem_req_ready = 1'b0;
    drain("t1_drain");

    // Decode stalled: credit fills after four fetches
    stall = 1'b1;
    imem_req_ready = 1'b1;
    issues = 0;
    expect_entry(32'hC);
    expect_entry(32'h10);
    expect_entry(32'h14);
    expect_entry(32'h18);
    for (int i = 0; i < 10; i++) begin
      at_neg();
      if (imem_req_valid && imem_req_ready)
        issues++;
      check("t2_pc_stall", pc_stall, 32'(i >= 4));
      next();
    end
    check("t2_issue_count", issues, 4);
    stall = 1'b0;
    imem_req_ready = 1'b0;
    drain("t2_drain");

    // Redirect to 0x10 while idle, then flush two in flight
    flush_target = 32'h10;
    flush_req = 1'b1;
    next();
    next();
    lat = 3;
    imem_req_ready = 1'b1;
    expect_entry(32'h100);
    next();
    next();
    flush_target = 32'h100;
    flush_req = 1'b1;
    next();
    imem_req_ready = 1'b0;
    at_neg();
    check("t3_drop_cnt", dut.drop_cnt, 2);
    check("t3_s2_valid", s2_valid, 0);
    drain("t3_drain");

    // Flush in the same cycle a response returns
    lat = 2;
    imem_req_ready = 1'b1;
    expect_entry(32'h300);
    next();
    next();
    flush_target = 32'h300;
    flush_req = 1'b1;
    next();
    imem_req_ready = 1'b0;
    at_neg();
    check("t4_drop_cnt", dut.drop_cnt, 1);
    drain("t4_drain");

    // Memory not ready: PC holds until first ready cycle
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      check("t5_pc_stall", pc_stall, 1);
      check("t5_req_addr", imem_req_addr, 32'h304);
      next();
    end
    imem_req_ready = 1'b1;
    expect_entry(32'h304);
    at_neg();
    check("t5_issue_stall", pc_stall, 0);
    check("t5_issue_addr", imem_req_addr, 32'h304);
    next();
    imem_req_ready = 1'b0;
    drain("t5_drain");

    // Reset with three fetches outstanding
    lat = 3;
    imem_req_ready = 1'b1;
    next();
    next();
    next();
    imem_req_ready = 1'b0;
    reset = 1'b1;
    at_neg();
    check("t6_outstanding_pre", dut.outstanding, 3);
    next();
    at_neg();
    check("t6_s2_valid", s2_valid, 0);
    check("t6_outstanding", dut.outstanding, 0);
    check("t6_drop_cnt", dut.drop_cnt, 0);
    check("t6_fifo_count", dut.fifo_count, 0);
    check("t6_req_valid", imem_req_valid, 0);
    next();
    reset = 1'b0;
    imem_req_ready = 1'b1;
    expect_entry(BOOT_ADDRESS);
    at_neg();
    check("t6_boot_valid", imem_req_valid, 1);
    check("t6_boot_addr", imem_req_addr, BOOT_ADDRESS);
    next();
    imem_req_ready = 1'b0;
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
